inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter INST_ADDR_WIDTH SHALL default to 9 and set the program counter width.
REQ-003 Parameter INST_WIDTH SHALL default to 32 and set the instruction word width.
REQ-004 Port clk SHALL be an input, 1 bit wide, and is the single clock with all state on its rising edge.
REQ-005 Port rst_n SHALL be an input, 1 bit wide, and is the synchronous active-low reset.
REQ-006 Port start_in SHALL be an input, 1 bit wide, and is a pulse that leaves IDLE or HALTED and begins fetching.
REQ-007 Port stall_in SHALL be an input, 1 bit wide, and requests that the downstream decode stage hold the current instruction.
REQ-008 Port branch_taken_in SHALL be an input, 1 bit wide, and is a redirect request from the decode/execute stage.
REQ-009 Port branch_pc_in SHALL be an input, INST_ADDR_WIDTH bits wide, and carries the PC of the branch instruction.
REQ-010 Port branch_offset_in SHALL be an input, INST_ADDR_WIDTH bits wide, and carries the branch offset produced by the decoder.
REQ-011 Port halt_cpu_in SHALL be an input, 1 bit wide, and is the halt indication from the decoder.
REQ-012 Port imem_addr_out SHALL be an output, INST_ADDR_WIDTH bits wide, and is the instruction memory address (equal to pc).
REQ-013 Port imem_en_out SHALL be an output, 1 bit wide, and is the instruction memory read enable; memory data holds while it is 0.
REQ-014 Port imem_data_in SHALL be an input, INST_WIDTH bits wide, and is the synchronous memory read data, valid 1 cycle after the enabled address.
REQ-015 Port inst_out SHALL be an output, INST_WIDTH bits wide, and is the instruction to the decoder, passed through from imem_data_in.
REQ-016 Port pc_out SHALL be an output, INST_ADDR_WIDTH bits wide, and is the address of inst_out.
REQ-017 Port inst_valid_out SHALL be an output, 1 bit wide, and indicates that inst_out/pc_out are meaningful.
REQ-018 Port fetch_count_out SHALL be an output, 16 bits wide, and counts instructions delivered (valid and not stalled).

Function
REQ-019 The FSM SHALL have states IDLE, RUN, FLUSH and HALTED.
REQ-020 Event priority SHALL be rst_n low > halt_cpu_in > branch_taken_in > stall_in > normal fetch.
REQ-021 In IDLE, imem_en_out SHALL be 0 and inst_valid_out 0; start_in moves the FSM to RUN with pc unchanged.
REQ-022 In RUN with no event, imem_en_out SHALL be 1, pc SHALL advance to pc+1 mod 2^INST_ADDR_WIDTH (0x1FF wraps to 0x000), and the next cycle SHALL show inst_valid_out=1 with pc_out equal to the fetched address.
REQ-023 While stall_in=1 in RUN, pc, pc_out, inst_valid_out and fetch_count_out SHALL hold, imem_en_out SHALL be 0, and inst_out SHALL therefore hold.
REQ-024 On branch_taken_in=1 in RUN or FLUSH, pc SHALL load (branch_pc_in + branch_offset_in) mod 2^INST_ADDR_WIDTH, imem_en_out SHALL be 0 that cycle, the FSM SHALL go to FLUSH, and inst_valid_out SHALL be 0 the next cycle; stall_in is ignored that cycle.
REQ-025 FLUSH SHALL last exactly one cycle, fetching from the target with imem_en_out=1 and inst_valid_out=0, then return to RUN, with the target instruction valid in the following cycle.
REQ-026 On halt_cpu_in=1 with inst_valid_out=1 in any state other than IDLE, the FSM SHALL enter HALTED, pc SHALL freeze at its current value, and inst_valid_out SHALL be 0 from the next cycle; a coincident branch_taken_in is ignored.
REQ-027 In HALTED, imem_en_out SHALL be 0, and start_in SHALL resume RUN from the frozen pc.
REQ-028 fetch_count_out SHALL increment when inst_valid_out=1 and stall_in=0, and SHALL saturate at 0xFFFF.
REQ-029 Back-to-back branches (branch_taken_in high in FLUSH) SHALL re-redirect and extend FLUSH by one cycle.

Reset
REQ-030 With rst_n=0 at a clock edge, the FSM SHALL go to IDLE with pc=0, pc_out=0, inst_valid_out=0, imem_en_out=0 and fetch_count_out=0, regardless of state, including mid-FLUSH or mid-stall.
REQ-031 After rst_n returns high, the module SHALL remain in IDLE until start_in.

Verification
REQ-032 A bench SHALL cover: reset, start_in pulse, memory holding word i at address i → inst_valid_out rises 1 cycle after start, pc_out = 0,1,2,..., and fetch_count_out = 3 after 3 valid cycles.
REQ-033 A bench SHALL cover: stall_in high for 4 cycles while pc_out=5 → pc_out, inst_out and fetch_count_out are held for 4 cycles with imem_en_out=0, and pc_out=6 on the first cycle after release.
REQ-034 A bench SHALL cover: branch_taken_in with branch_pc_in=0x1F0 and branch_offset_in=0x020 → next pc=0x010, one invalid bubble, then pc_out=0x010 valid.
REQ-035 A bench SHALL cover: halt_cpu_in together with branch_taken_in → HALTED, branch ignored, pc frozen; start_in resumes from the frozen pc.
REQ-036 A bench SHALL cover: sequential run from pc=0x1FE → pc_out sequence 0x1FE, 0x1FF, 0x000.
REQ-037 A bench SHALL cover: rst_n low during FLUSH → all outputs reach their reset values at the next edge, and the FSM is in IDLE.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Bundles the fetch stage's control, instruction-memory and decode-facing signals.
// The master modport is the fetch stage. The slave modport is its environment.
interface inst_fetch_if #(
  parameter int INST_ADDR_WIDTH = 9,
  parameter int INST_WIDTH      = 32
);
  logic                       start_in;
  logic                       stall_in;
  logic                       branch_taken_in;
  logic [INST_ADDR_WIDTH-1:0] branch_pc_in;
  logic [INST_ADDR_WIDTH-1:0] branch_offset_in;
  logic                       halt_cpu_in;
  logic [INST_ADDR_WIDTH-1:0] imem_addr_out;
  logic                       imem_en_out;
  logic [INST_WIDTH-1:0]      imem_data_in;
  logic [INST_WIDTH-1:0]      inst_out;
  logic [INST_ADDR_WIDTH-1:0] pc_out;
  logic                       inst_valid_out;
  logic [15:0]                fetch_count_out;

  modport master (
    input  start_in, stall_in, branch_taken_in, branch_pc_in, branch_offset_in,
           halt_cpu_in, imem_data_in,
    output imem_addr_out, imem_en_out, inst_out, pc_out, inst_valid_out,
           fetch_count_out
  );

  modport slave (
    output start_in, stall_in, branch_taken_in, branch_pc_in, branch_offset_in,
           halt_cpu_in, imem_data_in,
    input  imem_addr_out, imem_en_out, inst_out, pc_out, inst_valid_out,
           fetch_count_out
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: walks the PC through a synchronous instruction memory
// and hands each returned word to decode together with the address it came from.
//
// state   | meaning
// IDLE    | after reset; memory idle until start_in
// RUN     | sequential fetch; stall holds, branch redirects, halt freezes
// FLUSH   | bubble cycle fetching the branch target (repeats on back-to-back branch)
// HALTED  | stopped by decoder with pc frozen; start_in resumes from that pc
module inst_fetch #(
  parameter int INST_ADDR_WIDTH = 9,
  parameter int INST_WIDTH      = 32
) (
  input logic          clk,
  input logic          rst_n,
  inst_fetch_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic [INST_ADDR_WIDTH-1:0] PC_INC    = {{(INST_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [15:0]                COUNT_MAX = 16'hFFFF;

  state_t                     state_q, state_d;
  logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INST_ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
  logic                       valid_q, valid_d;
  logic [15:0]                count_q, count_d;
  logic                       imem_en;
  logic [INST_ADDR_WIDTH-1:0] branch_target;
  logic [INST_WIDTH-1:0]      inst_word;
  logic                       halt_ev;
  logic                       deliver;

  assign branch_target = bus.branch_pc_in + bus.branch_offset_in;
  // Halt only takes effect once the halting instruction is actually presented.
  assign halt_ev       = bus.halt_cpu_in & valid_q;
  assign deliver       = valid_q & ~bus.stall_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    imem_en  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_HALTED: begin
        valid_d = 1'b0;
        if (bus.start_in) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (halt_ev) begin
          state_d = ST_HALTED;
          valid_d = 1'b0;
        end else if (bus.branch_taken_in) begin
          state_d = ST_FLUSH;
          pc_d    = branch_target;
          valid_d = 1'b0;
        end else if (!bus.stall_in) begin
          imem_en  = 1'b1;
          pc_d     = pc_q + PC_INC;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
        end
      end

      // Nothing is valid in FLUSH, so stall has nothing to hold and is ignored.
      ST_FLUSH: begin
        if (halt_ev) begin
          state_d = ST_HALTED;
          valid_d = 1'b0;
        end else if (bus.branch_taken_in) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
        end else begin
          state_d  = ST_RUN;
          imem_en  = 1'b1;
          pc_d     = pc_q + PC_INC;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (deliver && (count_q != COUNT_MAX)) begin
      count_d = count_q + 16'd1;
    end
  end

  assign inst_word           = bus.imem_data_in;
  assign bus.inst_out        = inst_word;
  assign bus.imem_addr_out   = pc_q;
  assign bus.imem_en_out     = imem_en;
  assign bus.pc_out          = pc_out_q;
  assign bus.inst_valid_out  = valid_q;
  assign bus.fetch_count_out = count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_inst_fetch;
  localparam int AW = 9;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_if #(.INST_ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();

  inst_fetch #(.INST_ADDR_WIDTH(AW), .INST_WIDTH(IW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Memory holds word i at address i.
  function automatic logic [IW-1:0] mem_word(logic [AW-1:0] a);
    return IW'(a);
  endfunction

  always @(posedge clk) begin
    if (bus.imem_en_out) bus.imem_data_in <= mem_word(bus.imem_addr_out);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: "active" means the stage is fetching (RUN or bubble),
  // "redirect" means the previous cycle redirected so this one fetches the target.
  bit          m_active;
  bit          m_redirect;
  bit          m_valid;
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_pc_out;
  int          m_count;

  function automatic bit m_fetch_now();
    if (!m_active) return 1'b0;
    if (bus.halt_cpu_in && m_valid) return 1'b0;
    if (bus.branch_taken_in) return 1'b0;
    if (bus.stall_in && !m_redirect) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 0; m_redirect = 0; m_valid = 0;
      m_pc = '0; m_pc_out = '0; m_count = 0;
    end else begin
      bit fetch;
      fetch = m_fetch_now();
      if (m_valid && !bus.stall_in && m_count < 65535) m_count++;
      if (!m_active) begin
        m_valid = 0;
        if (bus.start_in) m_active = 1;
      end else if (bus.halt_cpu_in && m_valid) begin
        m_active = 0; m_valid = 0; m_redirect = 0;
      end else if (bus.branch_taken_in) begin
        m_pc = AW'((int'(bus.branch_pc_in) + int'(bus.branch_offset_in)) % (1 << AW));
        m_redirect = 1; m_valid = 0;
      end else if (fetch) begin
        m_pc_out = m_pc;
        m_pc = AW'((int'(m_pc) + 1) % (1 << AW));
        m_valid = 1; m_redirect = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("imem_en", 32'(bus.imem_en_out), 32'(m_fetch_now()));
      chk("imem_addr", 32'(bus.imem_addr_out), 32'(m_pc));
      chk("inst_valid", 32'(bus.inst_valid_out), 32'(m_valid));
      chk("fetch_count", 32'(bus.fetch_count_out), 32'(m_count));
      if (m_valid) begin
        chk("pc_out", 32'(bus.pc_out), 32'(m_pc_out));
        chk("inst_out", bus.inst_out, mem_word(m_pc_out));
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(bit st, bit sl, bit br, logic [AW-1:0] bpc, logic [AW-1:0] boff, bit h);
    bus.start_in = st; bus.stall_in = sl; bus.branch_taken_in = br;
    bus.branch_pc_in = bpc; bus.branch_offset_in = boff; bus.halt_cpu_in = h;
  endtask

  initial begin
    set_in(0, 0, 0, '0, '0, 0);
    rst_n = 1'b0;
    repeat (3) next();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(bus.inst_valid_out), 0);
    chk("rst_pc_out", 32'(bus.pc_out), 0);
    chk("rst_count", 32'(bus.fetch_count_out), 0);
    chk("rst_en", 32'(bus.imem_en_out), 0);
    next(); next();
    @(negedge clk);
    chk("idle_en", 32'(bus.imem_en_out), 0);

    // Start and sequential fetch from 0
    next(); set_in(1, 0, 0, '0, '0, 0);
    @(negedge clk); chk("start_en", 32'(bus.imem_en_out), 0);
    next(); set_in(0, 0, 0, '0, '0, 0);
    @(negedge clk);
    chk("first_en", 32'(bus.imem_en_out), 1);
    chk("first_addr", 32'(bus.imem_addr_out), 0);
    chk("first_valid", 32'(bus.inst_valid_out), 0);
    for (int i = 0; i < 5; i++) begin
      next();
      @(negedge clk);
      chk("seq_valid", 32'(bus.inst_valid_out), 1);
      chk("seq_pc_out", 32'(bus.pc_out), i);
      chk("seq_inst", bus.inst_out, i);
      chk("seq_count", 32'(bus.fetch_count_out), i);
    end

    // Stall four cycles while pc_out = 5
    next(); set_in(0, 1, 0, '0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next();
      @(negedge clk);
      chk("stall_pc_out", 32'(bus.pc_out), 5);
      chk("stall_inst", bus.inst_out, 5);
      chk("stall_count", 32'(bus.fetch_count_out), 5);
      chk("stall_en", 32'(bus.imem_en_out), 0);
    end
    next(); set_in(0, 0, 0, '0, '0, 0);
    next();
    @(negedge clk);
    chk("release_pc_out", 32'(bus.pc_out), 6);
    chk("release_count", 32'(bus.fetch_count_out), 6);

    // Branch 0x1F0 + 0x020 wraps to 0x010
    next(); set_in(0, 1, 1, 9'h1F0, 9'h020, 0);
    @(negedge clk); chk("br_en", 32'(bus.imem_en_out), 0);
    next(); set_in(0, 0, 0, '0, '0, 0);
    @(negedge clk);
    chk("flush_valid", 32'(bus.inst_valid_out), 0);
    chk("flush_addr", 32'(bus.imem_addr_out), 'h010);
    next();
    @(negedge clk);
    chk("br_tgt_valid", 32'(bus.inst_valid_out), 1);
    chk("br_tgt_pc", 32'(bus.pc_out), 'h010);

    // Halt with coincident branch: branch ignored, pc frozen at 0x012
    next(); set_in(0, 0, 1, 9'h100, 9'h005, 1);
    @(negedge clk); chk("halt_pc_out", 32'(bus.pc_out), 'h011);
    next(); set_in(0, 0, 0, '0, '0, 0);
    next();
    @(negedge clk);
    chk("halted_valid", 32'(bus.inst_valid_out), 0);
    chk("halted_en", 32'(bus.imem_en_out), 0);
    chk("halted_addr", 32'(bus.imem_addr_out), 'h012);
    next(); set_in(1, 0, 0, '0, '0, 0);
    next(); set_in(0, 0, 0, '0, '0, 0);
    next();
    @(negedge clk); chk("resume_pc_out", 32'(bus.pc_out), 'h012);

    // Wrap from 0x1FE
    next(); set_in(0, 0, 1, 9'h1FE, 9'h000, 0);
    next(); set_in(0, 0, 0, '0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      logic [AW-1:0] exp_pc;
      exp_pc = AW'(9'h1FE + i);
      next();
      @(negedge clk); chk("wrap_pc_out", 32'(bus.pc_out), 32'(exp_pc));
    end

    // Reset during FLUSH
    next(); set_in(0, 0, 1, 9'h0A0, 9'h00A, 0);
    next(); set_in(0, 0, 0, '0, '0, 0); rst_n = 1'b0;
    next(); rst_n = 1'b1;
    @(negedge clk);
    chk("flushrst_valid", 32'(bus.inst_valid_out), 0);
    chk("flushrst_pc_out", 32'(bus.pc_out), 0);
    chk("flushrst_count", 32'(bus.fetch_count_out), 0);
    chk("flushrst_addr", 32'(bus.imem_addr_out), 0);
    chk("flushrst_en", 32'(bus.imem_en_out), 0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      next();
      rst_n = ($urandom_range(0, 299) != 0);
      set_in($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 7) == 0, AW'($urandom), AW'($urandom),
             $urandom_range(0, 19) == 0);
    end
    next();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
